// File: rtl/tile_frame_reader_pkg.sv
// tile_frame_reader_pkg
// Shared constants for the tile map reader and its address mapper: tile image
// index classes, map geometry and ROM width. Also provides the helper that
// picks one 5-bit tile index out of a packed 40-bit map row.
// No ports (package). Optional feature macro used by the block: GRID_LINE_EN.
package tile_frame_reader_pkg;

  // Tile image indices published by the game core
  localparam int DARK        = 31;
  localparam int PLAYER_R    = 10;
  localparam int PLAYER_G    = 11;
  localparam int PLAYER_B    = 12;
  localparam int BULLET_R    = 13;
  localparam int BULLET_G    = 14;
  localparam int BULLET_B    = 15;
  localparam int BUBBLE      = 16;
  localparam int DARK_MIN    = 19;

  // Map and sprite geometry
  localparam int TILE_W      = 16;
  localparam int TILE_SHIFT  = $clog2(TILE_W);
  localparam int GRID_N      = 8;
  localparam int IDX_W       = 5;
  localparam int ROW_W       = GRID_N * IDX_W;
  localparam int ROM_AW      = 13;

  // Tile 0 lives in the top bits of the row, tile 7 in the bottom bits.
  function automatic logic [IDX_W-1:0] tile_idx(input logic [ROW_W-1:0] r,
                                                 input logic [2:0]       c);
    tile_idx = r[ROW_W-1 -: IDX_W];
    for (int i = 0; i < GRID_N; i++) begin
      if (c == 3'(i)) tile_idx = r[ROW_W-1-IDX_W*i -: IDX_W];
    end
  endfunction

endpackage

// File: rtl/tile_frame_reader_if.sv
// tile_frame_reader_if
// Bundles the VGA scan inputs, sprite ROM port and pixel outputs of the tile
// frame reader.
//   frame_start, h_cnt, v_cnt, de : scan position from the VGA timing block
//   rom_addr / rom_data            : synchronous sprite ROM (data 1 clk later)
//   pixel, pixel_valid             : RGB444 result toward the VGA pins
// Modports: master = surrounding system (timing + ROM), slave = the reader.
interface tile_frame_reader_if;
  import tile_frame_reader_pkg::*;

  logic              frame_start;
  logic [9:0]        h_cnt;
  logic [9:0]        v_cnt;
  logic              de;
  logic [ROM_AW-1:0] rom_addr;
  logic [11:0]       rom_data;
  logic [11:0]       pixel;
  logic              pixel_valid;

  modport master (
    output frame_start, h_cnt, v_cnt, de, rom_data,
    input  rom_addr, pixel, pixel_valid
  );

  modport slave (
    input  frame_start, h_cnt, v_cnt, de, rom_data,
    output rom_addr, pixel, pixel_valid
  );

endinterface

// File: rtl/tile_frame_reader_addr_gen.sv
// tile_addr_gen
// Combinational mapper from a screen position to a tile cell and texel.
// Kept separate so a future cursor overlay can reuse the same mapping.
// Ports:
//   h_cnt, v_cnt (in, 10)  screen column / line
//   de (in)                display enable
//   in_area (out)          position lies inside the 8x8 tile area and de=1
//   row, col (out, 3)      tile cell
//   tx, ty (out, 4)        texel inside the 16x16 sprite
//   on_grid (out)          only with GRID_LINE_EN: first pixel column/line of a cell
module tile_addr_gen
  import tile_frame_reader_pkg::*;
#(
  parameter int SCALE_SHIFT = 1,
  parameter int X_OFF       = 192,
  parameter int Y_OFF       = 112
) (
  input  logic [9:0] h_cnt,
  input  logic [9:0] v_cnt,
  input  logic       de,
  output logic       in_area,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic [3:0] tx,
  output logic [3:0] ty
`ifdef GRID_LINE_EN
  ,
  output logic       on_grid
`endif
);

  localparam logic [10:0] AREA      = 11'((GRID_N * TILE_W) << SCALE_SHIFT);
`ifdef GRID_LINE_EN
  localparam logic [10:0] CELL_MASK = 11'((TILE_W << SCALE_SHIFT) - 1);
`endif

  logic [10:0] dx;
  logic [10:0] dy;

  // The lower-bound checks are done on the raw counters so a negative offset
  // never wraps into a large unsigned value that looks in-area.
  always_comb begin
    dx      = {1'b0, h_cnt} - 11'(X_OFF);
    dy      = {1'b0, v_cnt} - 11'(Y_OFF);
    in_area = de && (h_cnt >= 10'(X_OFF)) && (v_cnt >= 10'(Y_OFF)) &&
              (dx < AREA) && (dy < AREA);
    col     = 3'(dx >> (TILE_SHIFT + SCALE_SHIFT));
    row     = 3'(dy >> (TILE_SHIFT + SCALE_SHIFT));
    tx      = 4'(dx >> SCALE_SHIFT);
    ty      = 4'(dy >> SCALE_SHIFT);
`ifdef GRID_LINE_EN
    on_grid = in_area && (((dx & CELL_MASK) == '0) || ((dy & CELL_MASK) == '0));
`endif
  end

endmodule

// File: rtl/tile_frame_reader.sv
// tile_frame_reader
// Reader side of the 8x8 tile map. Snapshots Row1..Row8 on frame_start so the
// picture never tears, maps each scan position to a sprite texel, reads the
// sprite ROM and emits the pixel a fixed 3 clk after the sample.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   Row1..Row8 (40)   tile map rows from the game core, Row1 on top
//   bus (slave)       scan inputs, sprite ROM port, pixel outputs
// Optional feature macro: GRID_LINE_EN draws 12'h444 cell borders.
module tile_frame_reader
  import tile_frame_reader_pkg::*;
#(
  parameter int          SCALE_SHIFT = 1,
  parameter int          X_OFF       = 192,
  parameter int          Y_OFF       = 112,
  parameter logic [11:0] BG_COLOR    = 12'h000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROW_W-1:0] Row1,
  input  logic [ROW_W-1:0] Row2,
  input  logic [ROW_W-1:0] Row3,
  input  logic [ROW_W-1:0] Row4,
  input  logic [ROW_W-1:0] Row5,
  input  logic [ROW_W-1:0] Row6,
  input  logic [ROW_W-1:0] Row7,
  input  logic [ROW_W-1:0] Row8,
  tile_frame_reader_if.slave bus
);

  logic [ROW_W-1:0]  shadow [GRID_N];
  logic              in_area;
  logic [2:0]        row;
  logic [2:0]        col;
  logic [3:0]        tx;
  logic [3:0]        ty;
  logic [IDX_W-1:0]  idx;
  logic              dark;
  logic [ROM_AW-1:0] addr_next;
  logic              s1_dark;
  logic              s1_de;
  logic              s2_dark;
  logic              s2_de;
`ifdef GRID_LINE_EN
  localparam logic [11:0] GRID_COLOR = 12'h444;
  logic              on_grid;
  logic              s1_grid;
  logic              s2_grid;
`endif

  tile_addr_gen #(
    .SCALE_SHIFT (SCALE_SHIFT),
    .X_OFF       (X_OFF),
    .Y_OFF       (Y_OFF)
  ) u_addr_gen (
    .h_cnt   (bus.h_cnt),
    .v_cnt   (bus.v_cnt),
    .de      (bus.de),
    .in_area (in_area),
    .row     (row),
    .col     (col),
    .tx      (tx),
    .ty      (ty)
`ifdef GRID_LINE_EN
    ,
    .on_grid (on_grid)
`endif
  );

  // Shadow map: starts all-DARK and only changes on frame_start, so the game
  // core may rewrite its rows at any time without tearing the picture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < GRID_N; i++) shadow[i] <= '1;
    end else if (bus.frame_start) begin
      shadow[0] <= Row1;
      shadow[1] <= Row2;
      shadow[2] <= Row3;
      shadow[3] <= Row4;
      shadow[4] <= Row5;
      shadow[5] <= Row6;
      shadow[6] <= Row7;
      shadow[7] <= Row8;
    end
  end

  // Decode reads the current shadow, so a frame_start coinciding with a
  // sample still shows the previous frame's map for that sample.
  always_comb begin
    idx       = tile_idx(shadow[row], col);
    dark      = (idx >= IDX_W'(DARK_MIN)) || !in_area;
    addr_next = dark ? '0 : {idx, ty, tx};
  end

  // Three-stage pipeline: address/flags, ROM access, colour select.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rom_addr    <= '0;
      s1_dark         <= 1'b0;
      s1_de           <= 1'b0;
      s2_dark         <= 1'b0;
      s2_de           <= 1'b0;
      bus.pixel       <= '0;
      bus.pixel_valid <= 1'b0;
    end else begin
      bus.rom_addr    <= addr_next;
      s1_dark         <= dark;
      s1_de           <= bus.de;
      s2_dark         <= s1_dark;
      s2_de           <= s1_de;
      bus.pixel       <= s2_dark ? BG_COLOR : bus.rom_data;
      bus.pixel_valid <= s2_de;
`ifdef GRID_LINE_EN
      if (s2_grid) bus.pixel <= GRID_COLOR;
`endif
    end
  end

`ifdef GRID_LINE_EN
  // Grid flag rides alongside dark so the override lands on the same pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_grid <= 1'b0;
      s2_grid <= 1'b0;
    end else begin
      s1_grid <= on_grid;
      s2_grid <= s1_grid;
    end
  end
`endif

endmodule
